// File: rtl/servo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_arb_pkg
// Description : Shared types and helpers for the servo access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_arb_pkg;

    localparam int ANGLE_W = 8;
    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PARK  = 2'd3
    } arb_state_t;

    function automatic logic [ANGLE_W-1:0] clamp_angle(
        input logic [ANGLE_W-1:0] angle,
        input logic [ANGLE_W-1:0] ceiling
    );
        return (angle > ceiling) ? ceiling : angle;
    endfunction

    // Index of the lowest set bit (highest priority); 0 when nothing is set.
    function automatic int lowest_set(input logic [MAX_REQ-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_limiter
// Description : Moves the output angle toward the target by a fixed step on
//               each step enable, landing exactly on the target.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_limiter
    import servo_arb_pkg::*;
#(
    parameter int STEP_DEG   = 1,
    parameter int PARK_ANGLE = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANGLE_W-1:0] i_target,
    input  logic               i_step_en,
    output logic [ANGLE_W-1:0] o_angle,
    output logic               o_settled
);

    localparam logic [ANGLE_W-1:0] c_step = ANGLE_W'(STEP_DEG);
    localparam logic [ANGLE_W-1:0] c_park = ANGLE_W'(PARK_ANGLE);

    logic [ANGLE_W-1:0] r_angle;
    logic [ANGLE_W-1:0] w_diff_up;
    logic [ANGLE_W-1:0] w_diff_dn;

    assign w_diff_up = i_target - r_angle;
    assign w_diff_dn = r_angle - i_target;

    // The last step is truncated so the ramp never overshoots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_angle <= c_park;
        end else if (i_step_en) begin
            if (r_angle < i_target) begin
                r_angle <= (w_diff_up > c_step) ? r_angle + c_step : i_target;
            end else if (r_angle > i_target) begin
                r_angle <= (w_diff_dn > c_step) ? r_angle - c_step : i_target;
            end
        end
    end

    assign o_angle   = r_angle;
    assign o_settled = (r_angle == i_target);

endmodule
`default_nettype wire

// File: rtl/servo_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : servo_access_arbiter
// Description : Fixed-priority, preemptive owner arbitration for one servo,
//               with minimum hold, park-on-idle and optional slew limiting
//               (enabled by defining SERVO_ARB_SLEW_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module servo_access_arbiter
    import servo_arb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int PARK_ANGLE  = 90,
    parameter int MAX_ANGLE   = 180,
    parameter int STEP_CYCLES = 50_000,
    parameter int STEP_DEG    = 1,
    parameter int MIN_HOLD    = 25_000_000,
    localparam int OWNER_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [NREQ-1:0]         req,
    input  logic [ANGLE_W*NREQ-1:0] angle_in,
    output logic [NREQ-1:0]         grant,
    output logic [OWNER_W-1:0]      owner_id,
    output logic                    busy,
    output logic [ANGLE_W-1:0]      angle_out,
    output logic                    settled,
    output logic                    switch_pulse
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  c_hold_last = HOLD_W'(MIN_HOLD - 1);
    localparam logic [ANGLE_W-1:0] c_park      = ANGLE_W'(PARK_ANGLE);
    localparam logic [ANGLE_W-1:0] c_max       = ANGLE_W'(MAX_ANGLE);

    arb_state_t         r_state;
    logic [NREQ-1:0]    r_grant;
    logic [OWNER_W-1:0] r_owner;
    logic [ANGLE_W-1:0] r_target;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_switch_pulse;

    logic [OWNER_W-1:0] w_low_idx;
    logic [NREQ-1:0]    w_low_onehot;
    logic [ANGLE_W-1:0] w_low_angle;
    logic [ANGLE_W-1:0] w_owner_angle;
    logic [NREQ-1:0]    w_higher;
    logic               w_any_req;
    logic               w_owner_req;
    logic               w_take;

    assign w_any_req     = |req;
    assign w_low_idx     = OWNER_W'(lowest_set(MAX_REQ'(req)));
    assign w_low_onehot  = NREQ'(1) << w_low_idx;
    assign w_low_angle   = clamp_angle(angle_in[ANGLE_W*w_low_idx +: ANGLE_W], c_max);
    assign w_owner_angle = clamp_angle(angle_in[ANGLE_W*r_owner +: ANGLE_W], c_max);
    assign w_owner_req   = req[r_owner];

    always_comb begin
        w_higher = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_higher[i] = req[i] && (i < int'(r_owner));
        end
    end

    // Any transition that hands the servo to the lowest-index requester.
    always_comb begin
        w_take = 1'b0;
        case (r_state)
            ST_IDLE:  w_take = w_any_req;
            ST_OWNED: w_take = |w_higher;
            ST_HOLD:  w_take = (|w_higher) ||
                               (!w_owner_req && (r_hold_cnt == c_hold_last) && w_any_req);
            ST_PARK:  w_take = w_any_req;
            default:  w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_owner        <= '0;
            r_target       <= c_park;
            r_hold_cnt     <= '0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_switch_pulse <= 1'b0;
            if (w_take) begin
                r_state        <= ST_OWNED;
                r_owner        <= w_low_idx;
                r_grant        <= w_low_onehot;
                r_target       <= w_low_angle;
                r_hold_cnt     <= '0;
                r_switch_pulse <= (w_low_onehot != r_grant);
            end else begin
                case (r_state)
                    ST_OWNED: begin
                        if (!w_owner_req) begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= '0;
                        end else begin
                            r_target <= w_owner_angle;
                        end
                    end
                    ST_HOLD: begin
                        if (w_owner_req) begin
                            r_state  <= ST_OWNED;
                            r_target <= w_owner_angle;
                        end else if (r_hold_cnt == c_hold_last) begin
                            r_state        <= ST_PARK;
                            r_grant        <= '0;
                            r_owner        <= '0;
                            r_target       <= c_park;
                            r_switch_pulse <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    ST_PARK: begin
                        if (settled) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign grant        = r_grant;
    assign owner_id     = r_owner;
    assign busy         = |r_grant;
    assign switch_pulse = r_switch_pulse;

`ifdef SERVO_ARB_SLEW_EN
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [STEP_W-1:0] r_step_cnt;
    logic              w_step_en;

    // Free-running step timebase; target changes do not restart it.
    assign w_step_en = (r_step_cnt == STEP_W'(STEP_CYCLES - 1));

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) r_step_cnt <= '0;
        else         r_step_cnt <= w_step_en ? '0 : r_step_cnt + 1'b1;
    end

    servo_slew_limiter #(
        .STEP_DEG   (STEP_DEG),
        .PARK_ANGLE (PARK_ANGLE)
    ) u_slew (
        .clk       (clk),
        .rst       (sys_rst),
        .i_target  (r_target),
        .i_step_en (w_step_en),
        .o_angle   (angle_out),
        .o_settled (settled)
    );
`else
    logic [ANGLE_W-1:0] r_angle;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) r_angle <= c_park;
        else         r_angle <= r_target;
    end

    assign angle_out = r_angle;
    assign settled   = (r_angle == r_target);
`endif

endmodule
`default_nettype wire

// File: tb/tb_servo_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_access_arbiter
// Description : Directed self-checking bench for servo_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_access_arbiter;

    localparam int NREQ = 3;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  req;
    logic [23:0] angle_in;
    logic [2:0]  grant;
    logic [1:0]  owner_id;
    logic        busy;
    logic [7:0]  angle_out;
    logic        settled;
    logic        switch_pulse;

    int checks = 0;
    int errors = 0;
    int npulse;

    always #5 clk = ~clk;

    servo_access_arbiter #(
        .NREQ        (NREQ),
        .PARK_ANGLE  (90),
        .MAX_ANGLE   (180),
        .STEP_CYCLES (4),
        .STEP_DEG    (1),
        .MIN_HOLD    (20)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .req          (req),
        .angle_in     (angle_in),
        .grant        (grant),
        .owner_id     (owner_id),
        .busy         (busy),
        .angle_out    (angle_out),
        .settled      (settled),
        .switch_pulse (switch_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Without slewing the angle lands after a fixed latency; with slewing wait (bounded).
    task automatic settle_to(input string tag, input logic [7:0] exp, input int n_off);
`ifdef SERVO_ARB_SLEW_EN
        int k = 0;
        while (angle_out !== exp && k < 2000) begin
            tick(1);
            k++;
        end
        check({tag, "_settled"}, 32'(settled), 32'd1);
`else
        tick(n_off);
`endif
        check(tag, 32'(angle_out), 32'(exp));
    endtask

    initial begin
        sys_rst  = 1'b1;
        req      = 3'b000;
        angle_in = {8'd100, 8'd50, 8'd30};
        tick(3);
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_owner",   32'(owner_id), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_angle",   32'(angle_out), 32'd90);
        check("rst_settled", 32'(settled), 32'd1);
        check("rst_pulse",   32'(switch_pulse), 32'd0);
        sys_rst = 1'b0;
        tick(2);
        check("idle_grant", 32'(grant), 32'd0);

        // Single low-priority requester
        req = 3'b100;
        tick(1);
        check("req2_grant", 32'(grant), 32'b100);
        check("req2_pulse", 32'(switch_pulse), 32'd1);
        check("req2_owner", 32'(owner_id), 32'd2);
        check("req2_busy",  32'(busy), 32'd1);
        check("req2_angle_latency", 32'(angle_out), 32'd90);
        settle_to("req2_angle", 8'd100, 1);
        check("req2_pulse_drop", 32'(switch_pulse), 32'd0);

        // Preemption by index 0
        req = 3'b101;
        tick(1);
        check("pre_grant", 32'(grant), 32'b001);
        check("pre_owner", 32'(owner_id), 32'd0);
        check("pre_pulse", 32'(switch_pulse), 32'd1);
        settle_to("pre_angle", 8'd30, 1);
        angle_in[7:0] = 8'd40;
        settle_to("track_angle", 8'd40, 2);

        // Owner drops with a lower-priority requester waiting: full hold
        req = 3'b110;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (switch_pulse) npulse++;
        end
        check("hold_grant", 32'(grant), 32'b001);
        check("hold_no_pulse", 32'(npulse), 32'd0);
        tick(1);
        check("handoff_grant", 32'(grant), 32'b010);
        check("handoff_owner", 32'(owner_id), 32'd1);
        check("handoff_pulse", 32'(switch_pulse), 32'd1);
        settle_to("handoff_angle", 8'd50, 1);

        // Higher-priority request cuts a hold short
        req = 3'b100;
        tick(4);
        check("hold2_grant", 32'(grant), 32'b010);
        req = 3'b101;
        tick(1);
        check("hold_preempt_grant", 32'(grant), 32'b001);
        check("hold_preempt_pulse", 32'(switch_pulse), 32'd1);
        settle_to("hold_preempt_angle", 8'd40, 1);

        // Everyone drops: hold, then park
        req = 3'b000;
        tick(20);
        check("idle_hold_grant", 32'(grant), 32'b001);
        tick(1);
        check("park_grant", 32'(grant), 32'd0);
        check("park_pulse", 32'(switch_pulse), 32'd1);
        check("park_busy",  32'(busy), 32'd0);
        check("park_owner", 32'(owner_id), 32'd0);
        settle_to("park_angle", 8'd90, 1);
        tick(2);
        check("park_settled", 32'(settled), 32'd1);

        // Out-of-range angle saturates
        angle_in[23:16] = 8'd200;
        req = 3'b100;
        tick(1);
        check("clamp_grant", 32'(grant), 32'b100);
        settle_to("clamp_angle", 8'd180, 1);

        // Asynchronous reset in the middle of a move
        angle_in[23:16] = 8'd10;
        tick(6);
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_angle",   32'(angle_out), 32'd90);
        check("arst_grant",   32'(grant), 32'd0);
        check("arst_busy",    32'(busy), 32'd0);
        check("arst_settled", 32'(settled), 32'd1);
        req = 3'b000;
        tick(1);
        sys_rst = 1'b0;
        tick(1);

        // Simultaneous requests, then owner drop with higher request same cycle
        req = 3'b110;
        tick(1);
        check("simul_grant", 32'(grant), 32'b010);
        req = 3'b001;
        tick(1);
        check("drop_pre_grant", 32'(grant), 32'b001);
        check("drop_pre_pulse", 32'(switch_pulse), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
